// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_seq_ctrl (with helper adder_cla)                     |
// | Description : Multi-word sequential adder. Computes A + B + Cin over     |
// |               NWORDS cycles with a single 32-bit carry-lookahead adder,  |
// |               least significant word first, valid/ready on both sides.   |
// |               Optional macro ADDER_SEQ_SUB_EN adds sub_i (A - B).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
module adder_cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);

  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [31:0] w_c;
  logic [7:0]  w_bg;
  logic [7:0]  w_bp;
  logic [7:0]  w_bcin;

  assign w_p = a_i ^ b_i;
  assign w_g = a_i & b_i;

  for (genvar k = 0; k < 8; k++) begin : g_blk
    localparam int BASE = 4 * k;
    logic [3:0] w_lp;
    logic [3:0] w_lg;
    logic       w_ci;
    assign w_lp = w_p[BASE +: 4];
    assign w_lg = w_g[BASE +: 4];
    assign w_ci = w_bcin[k];
    // Carries inside the group are formed directly from the group carry-in.
    assign w_c[BASE]     = w_ci;
    assign w_c[BASE + 1] = w_lg[0] | (w_lp[0] & w_ci);
    assign w_c[BASE + 2] = w_lg[1] | (w_lp[1] & w_lg[0]) | (w_lp[1] & w_lp[0] & w_ci);
    assign w_c[BASE + 3] = w_lg[2] | (w_lp[2] & w_lg[1]) | (w_lp[2] & w_lp[1] & w_lg[0])
                         | (w_lp[2] & w_lp[1] & w_lp[0] & w_ci);
    assign w_bg[k] = w_lg[3] | (w_lp[3] & w_lg[2]) | (w_lp[3] & w_lp[2] & w_lg[1])
                   | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
    assign w_bp[k] = &w_lp;
  end

  // Group-level carry chain using each group's generate/propagate pair.
  always_comb begin
    logic carry;
    carry  = c_i;
    w_bcin = '0;
    for (int k = 0; k < 8; k++) begin
      w_bcin[k] = carry;
      carry     = w_bg[k] | (w_bp[k] & carry);
    end
    c_o = carry;
  end

  assign s_o = w_p ^ w_c;

endmodule

module adder_seq_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                   sub_i,
`endif
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [32*NWORDS-1:0]   A_i,
  input  logic [32*NWORDS-1:0]   B_i,
  input  logic                   Cin_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [32*NWORDS-1:0]   S_o,
  output logic                   Cout_o,
  output logic                   busy_o
);

  localparam int W    = 32 * NWORDS;
  localparam int IDXW = $clog2(NWORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      s_q;
  logic              carry_q;
  logic              cout_q;
  logic              sub_q;

  logic              w_sub_in;
  logic              w_accept;
  logic              w_last;
  logic              w_run;
  logic [31:0]       w_b_word;
  logic [31:0]       w_sum;
  logic              w_sum_co;

`ifdef ADDER_SEQ_SUB_EN
  assign w_sub_in = sub_i;
`else
  assign w_sub_in = 1'b0;
`endif

  assign in_ready_o  = (state_q == ST_IDLE) & ~rst_i;
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN) | (state_q == ST_DONE);
  assign S_o         = s_q;
  assign Cout_o      = cout_q;

  assign w_accept = in_valid_i & in_ready_o;
  assign w_last   = (idx_q == IDXW'(NWORDS - 1));
  assign w_run    = (state_q == ST_RUN);

  // Subtraction feeds the one's complement of B; the initial carry supplies the +1.
  assign w_b_word = b_q[31:0] ^ {32{sub_q}};

  adder_cla u_adder (
    .a_i (a_q[31:0]),
    .b_i (w_b_word),
    .c_i (carry_q),
    .s_o (w_sum),
    .c_o (w_sum_co)
  );

  // State and word index registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: one word per RUN cycle, hold in DONE until the result is taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (w_last) state_d = ST_DONE;
        else        idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Operand capture, word shifting, carry chaining and result-word writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else if (w_accept) begin
      a_q     <= A_i;
      b_q     <= B_i;
      sub_q   <= w_sub_in;
      carry_q <= w_sub_in ? 1'b1 : Cin_i;
    end else if (w_run) begin
      // Operands shift down so the current word is always at the bottom.
      a_q     <= {32'd0, a_q[W-1:32]};
      b_q     <= {32'd0, b_q[W-1:32]};
      carry_q <= w_sum_co;
      // Only the word being computed is written so S_o keeps the previous result elsewhere.
      for (int k = 0; k < NWORDS; k++) begin
        if (idx_q == IDXW'(k)) s_q[32*k +: 32] <= w_sum;
      end
      if (w_last) cout_q <= w_sum_co;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_adder_seq_ctrl                                          |
// | Description : Self-checking bench for adder_seq_ctrl (NWORDS = 4).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_adder_seq_ctrl;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          cout;
  logic          busy;
  logic          sub_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NWORDS(NW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
`ifdef ADDER_SEQ_SUB_EN
    .sub_i       (sub_v),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .A_i         (a),
    .B_i         (b),
    .Cin_i       (cin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .S_o         (s),
    .Cout_o      (cout),
    .busy_o      (busy)
  );

  // Reference: {carry, sum} as a wide integer result.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    logic [W:0] r;
    if (sb) r = {(x >= y) ? 1'b1 : 1'b0, x - y};
    else    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns number of edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One complete operation with latency, result and handshake checks.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb, input logic early_ready);
    logic [W:0] e;
    int n;
    int lat;
    e = model(x, y, ci, sb);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    a = x; b = y; cin = ci; sub_v = sb;
    in_valid  = 1'b1;
    out_ready = early_ready;
    tick();
    in_valid = 1'b0;
    a = rnd(); b = rnd(); cin = ~ci; sub_v = ~sb;
    check({tag, "_busy"}, {{W{1'b0}}, busy}, 1);
    check({tag, "_rdy_run"}, {{W{1'b0}}, in_ready}, 0);
    wait_valid(lat);
    check({tag, "_lat"}, (W+1)'(lat), (W+1)'(NW));
    check({tag, "_sum"}, {1'b0, s}, {1'b0, e[W-1:0]});
    check({tag, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, e[W]});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_after"}, {{W{1'b0}}, out_valid}, 0);
    check({tag, "_hold_sum"}, {1'b0, s}, {1'b0, e[W-1:0]});
  endtask

  initial begin
    logic [W:0]   e1;
    logic [W:0]   e2;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_in_ready", {{W{1'b0}}, in_ready}, 0);
    check("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("rst_busy", {{W{1'b0}}, busy}, 0);
    check("rst_sum", {1'b0, s}, 0);
    check("rst_cout", {{W{1'b0}}, cout}, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {{W{1'b0}}, in_ready}, 1);

    // Carry ripples through every word
    do_op("allones", {W{1'b1}}, W'(1), 1'b0, 1'b0, 1'b0);
    // Carry-in only
    do_op("cin_only", '0, '0, 1'b1, 1'b0, 1'b0);

    // Random operations, some with out_ready high before out_valid
    for (int i = 0; i < 8; i++) begin
      do_op("rand", rnd(), rnd(), 1'($urandom), 1'b0, 1'($urandom));
    end
    // Word-boundary carry patterns
    do_op("half_carry", {{(W/2){1'b0}}, {(W/2){1'b1}}}, W'(1), 1'b0, 1'b0, 1'b0);
    do_op("max_max", {W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, 1'b1);

    // Back-pressure in DONE for three cycles; in_valid there is ignored
    x = rnd(); y = rnd();
    e1 = model(x, y, 1'b1, 1'b0);
    a = x; b = y; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", (W+1)'(lat), (W+1)'(NW));
    for (int i = 0; i < 3; i++) begin
      a = rnd(); b = rnd(); in_valid = 1'b1;
      check("bp_valid", {{W{1'b0}}, out_valid}, 1);
      check("bp_ready", {{W{1'b0}}, in_ready}, 0);
      check("bp_sum", {1'b0, s}, {1'b0, e1[W-1:0]});
      check("bp_cout", {{W{1'b0}}, cout}, {{W{1'b0}}, e1[W]});
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", {{W{1'b0}}, in_ready}, 1);
    check("bp_idle_busy", {{W{1'b0}}, busy}, 0);
    check("bp_keep_sum", {1'b0, s}, {1'b0, e1[W-1:0]});
    tick();
    check("bp_no_queue", {{W{1'b0}}, busy}, 0);

    // Reset in the middle of RUN word 2
    a = {W{1'b1}}; b = {W{1'b1}}; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_busy", {{W{1'b0}}, busy}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {{W{1'b0}}, out_valid}, 0);
    check("mid_rst_busy", {{W{1'b0}}, busy}, 0);
    check("mid_rst_ready", {{W{1'b0}}, in_ready}, 0);
    check("mid_rst_sum", {1'b0, s}, 0);
    check("mid_rst_cout", {{W{1'b0}}, cout}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_ready", {{W{1'b0}}, in_ready}, 1);
    check("mid_rel_valid", {{W{1'b0}}, out_valid}, 0);
    do_op("after_rst", rnd(), rnd(), 1'b1, 1'b0, 1'b0);

    // in_valid held high across two operations with out_ready high
    x = rnd(); y = rnd();
    e1 = model(x, y, 1'b0, 1'b0);
    a = x; b = y; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    x = rnd(); y = rnd();
    e2 = model(x, y, 1'b1, 1'b0);
    a = x; b = y; cin = 1'b1;
    wait_valid(lat);
    check("b2b_lat1", (W+1)'(lat), (W+1)'(NW));
    check("b2b_sum1", {1'b0, s}, {1'b0, e1[W-1:0]});
    check("b2b_cout1", {{W{1'b0}}, cout}, {{W{1'b0}}, e1[W]});
    tick();
    check("b2b_gap_ready", {{W{1'b0}}, in_ready}, 1);
    check("b2b_gap_valid", {{W{1'b0}}, out_valid}, 0);
    tick();
    in_valid = 1'b0;
    check("b2b_accept2", {{W{1'b0}}, busy}, 1);
    wait_valid(lat);
    check("b2b_lat2", (W+1)'(lat), (W+1)'(NW));
    check("b2b_sum2", {1'b0, s}, {1'b0, e2[W-1:0]});
    check("b2b_cout2", {{W{1'b0}}, cout}, {{W{1'b0}}, e2[W]});
    tick();
    out_ready = 1'b0;

`ifdef ADDER_SEQ_SUB_EN
    // Subtraction: borrow and no-borrow cases, plus random
    do_op("sub_5m7", W'(5), W'(7), 1'b0, 1'b1, 1'b0);
    do_op("sub_7m5", W'(7), W'(5), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_op("sub_rand", rnd(), rnd(), 1'($urandom), 1'b1, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
